led_pattern_engine: RTL and testbench

// - Consumer of the on-chip oscillator clock (GW1NR-9C OSC, 250 MHz / FREQ_DIV 80 = 3.125 MHz).
// - Divides that clock to a 100 Hz step tick.
// - Debounces the user button and steps through three LED display modes.
// - Drives the board's active-low LED bank directly.

---
 rtl/led_pattern_engine_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 67 ++++++
 rtl/led_pattern_engine.sv | 156 +++++++++++++++
 tb/tb_led_pattern_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_engine_pkg.sv
// Shared mode encodings, step constants and mode sequencing helper for the
// LED pattern engine.
package led_pattern_engine_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Ticks per blink toggle (1 Hz at a 100 Hz tick)
    localparam int unsigned BLINK_STEPS = 50;
    // Ticks per chase position
    localparam int unsigned CHASE_STEPS = 10;
    // Duty increment per tick in BREATHE
    localparam int unsigned BREATHE_INC = 4;
    // step counter must hold the longest step period
    localparam int unsigned STEP_W = $clog2(BLINK_STEPS);

    // Mode order followed on each accepted button press
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_BLINK:   return MODE_CHASE;
            MODE_CHASE:   return MODE_BREATHE;
            default:      return MODE_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: two-flop synchronizer followed by a tick-sampled
// debouncer. Emits a one-cycle press pulse on a released->pressed change.
module btn_debounce #(
    parameter int unsigned DB_TICKS = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int unsigned DB_W = $clog2(DB_TICKS + 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            db_q;      // debounced level, 1 = released
    logic            db_d;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            differ;
    logic            flip;

    // Synchronize the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive mismatching tick samples; flip when the run completes
    always_comb begin
        differ   = (sync2_q != db_q);
        flip     = tick_i && differ && (db_cnt_q == DB_W'(DB_TICKS - 1));
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        if (tick_i) begin
            if (!differ) begin
                db_cnt_d = '0;
            end else if (flip) begin
                db_cnt_d = '0;
                db_d     = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q     <= 1'b1;
            db_cnt_q <= '0;
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Press fires in the tick cycle that accepts a released->pressed change
    assign press_o = flip && db_q;

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescales clk to a step tick, debounces the button,
// cycles BLINK/CHASE/BREATHE on each press and drives active-low LEDs.
module led_pattern_engine
    import led_pattern_engine_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 3125000,
    parameter int unsigned TICK_HZ  = 100,
    parameter int unsigned NUM_LEDS = 6,
    parameter int unsigned DB_TICKS = 2,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_n,
    output logic [NUM_LEDS-1:0] led_n,
    output logic [1:0]          mode,
    output logic                tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_STEP = PWM_BITS'(BREATHE_INC);
    localparam logic [PWM_BITS-1:0] DUTY_TOP  = PWM_BITS'((1 << PWM_BITS) - BREATHE_INC);

    logic [PRE_W-1:0]    pre_cnt_q;
    logic [PRE_W-1:0]    pre_cnt_d;
    logic                tick_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic                press;

    mode_e               mode_q;
    mode_e               enter_mode;
    logic                enter;
    logic [STEP_W-1:0]   step_q;
    logic [NUM_LEDS-1:0] pattern_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                dir_up_q;
    logic [NUM_LEDS-1:0] led_n_q;

    // Next prescaler count, wrapping at DIV-1
    always_comb begin
        pre_cnt_d = (pre_cnt_q == PRE_W'(DIV - 1)) ? '0 : pre_cnt_q + 1'b1;
    end

    // Prescaler; tick is registered so it is high while pre_cnt sits at DIV-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= (pre_cnt_d == PRE_W'(DIV - 1));
        end
    end

    // Free-running PWM counter for BREATHE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
        end
    end

    btn_debounce #(
        .DB_TICKS (DB_TICKS)
    ) u_btn_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_i  (tick_q),
        .btn_n_i (btn_n),
        .press_o (press)
    );

    // Decide whether this cycle enters a new mode (press, or recovery from 3)
    always_comb begin
        enter      = 1'b0;
        enter_mode = mode_q;
        if (mode_q == MODE_RSVD) begin
            enter      = 1'b1;
            enter_mode = MODE_BLINK;
        end else if (press) begin
            enter      = 1'b1;
            enter_mode = next_mode(mode_q);
        end
    end

    // Mode FSM and per-mode pattern generators; a mode change wins over a tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= MODE_BLINK;
            step_q    <= '0;
            pattern_q <= '0;
            duty_q    <= '0;
            dir_up_q  <= 1'b1;
        end else if (enter) begin
            mode_q    <= enter_mode;
            step_q    <= '0;
            pattern_q <= (enter_mode == MODE_CHASE) ? NUM_LEDS'(1) : '0;
            duty_q    <= '0;
            dir_up_q  <= 1'b1;
        end else if (tick_q) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (step_q == STEP_W'(BLINK_STEPS - 1)) begin
                        step_q    <= '0;
                        pattern_q <= ~pattern_q;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                MODE_CHASE: begin
                    if (step_q == STEP_W'(CHASE_STEPS - 1)) begin
                        step_q    <= '0;
                        pattern_q <= {pattern_q[NUM_LEDS-2:0], pattern_q[NUM_LEDS-1]};
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                MODE_BREATHE: begin
                    step_q <= (step_q == STEP_W'(BLINK_STEPS - 1)) ? '0 : step_q + 1'b1;
                    // dir turns as the endpoint is reached so each endpoint lasts one tick
                    if (dir_up_q) begin
                        duty_q <= duty_q + DUTY_STEP;
                        if ((duty_q + DUTY_STEP) == DUTY_TOP) begin
                            dir_up_q <= 1'b0;
                        end
                    end else begin
                        duty_q <= duty_q - DUTY_STEP;
                        if ((duty_q - DUTY_STEP) == '0) begin
                            dir_up_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered active-low LED drive, one cycle behind pattern/duty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_n_q <= '1;
        end else if (mode_q == MODE_BREATHE) begin
            led_n_q <= {NUM_LEDS{~(pwm_q < duty_q)}};
        end else begin
            led_n_q <= ~pattern_q;
        end
    end

    assign led_n = led_n_q;
    assign mode  = mode_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed button/reset stimulus,
// a tick-level behavioural model compared every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_led_pattern_engine;

    localparam int DIV = 10;
    localparam int N   = 6;
    localparam int DBT = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_n = 1'b1;
    logic [N-1:0] led_n;
    logic [1:0]   mode;
    logic         tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pattern_engine #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .NUM_LEDS (N),
        .DB_TICKS (DBT),
        .PWM_BITS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .led_n (led_n),
        .mode  (mode),
        .tick  (tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State is described by counts: edges since reset, ticks since entering
    // the mode, presses so far. LED pattern is a pure function of those.
    int unsigned  m_n;        // rising edges since reset release
    bit           m_tick;
    bit           m_s1, m_s2; // button as seen through two flops
    bit           m_db;       // debounced level, 1 = released
    bit           hist[$];    // tick samples since the last accepted change
    int           m_mode;
    int           m_T;        // ticks counted in the current mode
    logic [N-1:0] m_ledn;
    bit           m_valid = 1'b0;
    bit           flip, press, all_diff;

    function automatic logic [N-1:0] pattern_of(input int md, input int t, input int unsigned n);
        logic [N-1:0] one;
        int k;
        int duty;
        one = 1;
        case (md)
            0: return ((t / 50) % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
            1: return one << ((t / 10) % N);
            default: begin
                k    = t % 126;
                duty = (k <= 63) ? 4 * k : 4 * (126 - k);
                return (int'(n % 256) < duty) ? {N{1'b1}} : {N{1'b0}};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n     = 0;
            m_tick  = 1'b0;
            m_s1    = 1'b1;
            m_s2    = 1'b1;
            m_db    = 1'b1;
            hist.delete();
            m_mode  = 0;
            m_T     = 0;
            m_ledn  = {N{1'b1}};
            m_valid = 1'b1;
        end else begin
            m_ledn = ~pattern_of(m_mode, m_T, m_n);
            flip   = 1'b0;
            if (m_tick) begin
                hist.push_back(m_s2);
                if (hist.size() > DBT) void'(hist.pop_front());
                if (hist.size() == DBT) begin
                    all_diff = 1'b1;
                    foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
                    flip = all_diff;
                end
            end
            press = flip && m_db;
            if (flip) begin
                m_db = ~m_db;
                hist.delete();
            end
            if (press) begin
                m_mode = (m_mode + 1) % 3;
                m_T    = 0;
            end else if (m_tick) begin
                m_T++;
            end
            m_s2   = m_s1;
            m_s1   = btn_n;
            m_n++;
            m_tick = ((m_n % DIV) == DIV - 1);
        end
    end

    // Compare DUT against the model every cycle, mid-period
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_led_n", led_n, m_ledn);
            check("model_mode", mode, m_mode);
            check("model_tick", tick, m_tick);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ticks(input int k);
        int seen;
        int budget;
        seen   = 0;
        budget = 0;
        while (seen < k) begin
            @(negedge clk);
            budget++;
            if (tick) seen++;
            if (budget > k * DIV + 2 * DIV) begin
                check("wait_ticks_timeout", seen, k);
                return;
            end
        end
    endtask

    // Two edges: pattern updates on the first, led_n on the second
    task automatic settle();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_mode(input int target);
        int n;
        n = 0;
        while (mode !== 2'(target) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_mode", mode, target);
    endtask

    logic [N-1:0] exp_led;
    logic [N-1:0] one6;

    initial begin
        one6 = 1;
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_led_n", led_n, 6'b111111);
        check("reset_mode", mode, 0);
        check("reset_tick", tick, 0);
        rst_n = 1'b1;

        // tick high only during periods 10, 20, 30 after release
        for (int p = 1; p <= 35; p++) begin
            if (p > 1) @(negedge clk);
            check("tick_period", tick, (p % 10 == 0) ? 1 : 0);
        end

        // BLINK: toggle after tick 50, back after tick 100
        wait_ticks(46);
        settle();
        check("blink_before_50", led_n, 6'b111111);
        wait_ticks(1);
        settle();
        check("blink_after_50", led_n, 6'b000000);
        wait_ticks(50);
        settle();
        check("blink_after_100", led_n, 6'b111111);

        // Glitch lasting one tick sample: no mode change
        btn_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_n = 1'b1;
        wait_ticks(4);
        check("glitch_mode", mode, 0);

        // Press into CHASE; press coincides with a tick that must not count
        btn_n = 1'b0;
        wait_mode(1);
        btn_n = 1'b1;
        check("press1_mode", mode, 1);
        wait_ticks(9);
        settle();
        check("chase_hold_9", led_n, 6'b111110);
        wait_ticks(1);
        settle();
        check("chase_step_10", led_n, 6'b111101);
        for (int k = 2; k <= 7; k++) begin
            wait_ticks(10);
            settle();
            exp_led = ~(one6 << (k % N));
            check("chase_step", led_n, exp_led);
            if (k == 6) check("chase_wrap_60", led_n, 6'b111110);
        end

        // BREATHE: duty 0 right after entry keeps LEDs off
        btn_n = 1'b0;
        wait_mode(2);
        btn_n = 1'b1;
        check("press2_mode", mode, 2);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("breathe_duty0", led_n, 6'b111111);
        end
        wait_ticks(140);

        // Back to BLINK
        btn_n = 1'b0;
        wait_mode(0);
        btn_n = 1'b1;
        check("press3_mode", mode, 0);
        wait_ticks(4);

        // Into CHASE, then reset mid-run
        btn_n = 1'b0;
        wait_mode(1);
        btn_n = 1'b1;
        wait_ticks(15);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_led_n", led_n, 6'b111111);
        check("midreset_mode", mode, 0);
        check("midreset_tick", tick, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(55);
        settle();
        check("resume_mode", mode, 0);
        check("resume_blink", led_n, 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
